// File: rtl/inst_d_if.sv
// ---------------------------------------------------------------------------
// inst_d_if : fetch / write-back / ID-EX bundle for the inst_d decode stage
// Rev 1.0   : stat_* members exist only when DEC_STATS_EN is defined
// ---------------------------------------------------------------------------
`default_nettype none

interface inst_d_if;
    logic [31:0] instruction;
    logic [31:0] pc4_dc;
    logic        if_valid;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        hazard;
    logic        ex_valid;
    logic [5:0]  ex_op;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_dest;
    logic        ex_wr_en;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_branch;
    logic [31:0] ex_pc4;
    logic        halted;
`ifdef DEC_STATS_EN
    logic [31:0] stat_inst;
    logic [31:0] stat_stall;
`endif

    modport slave (
        input  instruction, pc4_dc, if_valid, flush, wb_en, wb_addr, wb_data,
        output hazard, ex_valid, ex_op, ex_rs_val, ex_rt_val, ex_imm, ex_dest,
               ex_wr_en, ex_mem_rd, ex_mem_wr, ex_branch, ex_pc4, halted
`ifdef DEC_STATS_EN
        , output stat_inst, stat_stall
`endif
    );

    modport master (
        output instruction, pc4_dc, if_valid, flush, wb_en, wb_addr, wb_data,
        input  hazard, ex_valid, ex_op, ex_rs_val, ex_rt_val, ex_imm, ex_dest,
               ex_wr_en, ex_mem_rd, ex_mem_wr, ex_branch, ex_pc4, halted
`ifdef DEC_STATS_EN
        , input stat_inst, stat_stall
`endif
    );
endinterface

`default_nettype wire

// File: rtl/inst_d.sv
// ---------------------------------------------------------------------------
// inst_d : IF/ID register, decode, 32x32 register file, load-use stall, ID/EX
// Rev 1.0   : DEC_STATS_EN adds stat_inst / stat_stall counters
// ---------------------------------------------------------------------------
`default_nettype none

module inst_d #(
    parameter int          NREGS     = 32,
    parameter logic [31:0] RESET_PC4 = 32'h0
) (
    input  logic     clk,
    input  logic     rst,
    inst_d_if.slave  bus
);

    localparam logic [5:0] c_op_ldw  = 6'h0C;
    localparam logic [5:0] c_op_stw  = 6'h0D;
    localparam logic [5:0] c_op_bz   = 6'h0E;
    localparam logic [5:0] c_op_beq  = 6'h0F;
    localparam logic [5:0] c_op_jr   = 6'h10;
    localparam logic [5:0] c_op_halt = 6'h11;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic [31:0] r_regs [NREGS];

    logic [31:0] r_ex_rs_val, r_ex_rt_val, r_ex_imm, r_ex_pc4;
    logic [5:0]  r_ex_op;
    logic [4:0]  r_ex_dest;
    logic        r_ex_valid, r_ex_wr_en, r_ex_mem_rd, r_ex_mem_wr, r_ex_branch;

    logic [5:0]  w_op;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic        w_rd_rs, w_rd_rt, w_wr_en, w_mem_rd, w_mem_wr, w_branch;
    logic [4:0]  w_dest;
    logic [31:0] w_rs_val, w_rt_val;
    logic        w_load_use, w_hazard, w_issue;

    assign w_op = r_ifid_instr[31:26];
    assign w_rs = r_ifid_instr[25:21];
    assign w_rt = r_ifid_instr[20:16];
    assign w_rd = r_ifid_instr[15:11];

    always_comb begin
        w_rd_rs  = 1'b0;
        w_rd_rt  = 1'b0;
        w_wr_en  = 1'b0;
        w_mem_rd = 1'b0;
        w_mem_wr = 1'b0;
        w_branch = 1'b0;
        w_dest   = 5'd0;
        if (w_op <= 6'd11) begin
            // even opcodes are R-type, odd are immediate forms
            w_rd_rs = 1'b1;
            w_wr_en = 1'b1;
            if (!w_op[0]) begin
                w_rd_rt = 1'b1;
                w_dest  = w_rd;
            end else begin
                w_dest  = w_rt;
            end
        end else begin
            case (w_op)
                c_op_ldw: begin
                    w_rd_rs  = 1'b1;
                    w_wr_en  = 1'b1;
                    w_mem_rd = 1'b1;
                    w_dest   = w_rt;
                end
                c_op_stw: begin
                    w_rd_rs  = 1'b1;
                    w_rd_rt  = 1'b1;
                    w_mem_wr = 1'b1;
                end
                c_op_bz, c_op_jr: begin
                    w_rd_rs  = 1'b1;
                    w_branch = 1'b1;
                end
                c_op_beq: begin
                    w_rd_rs  = 1'b1;
                    w_rd_rt  = 1'b1;
                    w_branch = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // write-first: a same-cycle write-back to a source register is forwarded
    assign w_rs_val = (w_rs == 5'd0) ? 32'd0 :
                      (bus.wb_en && bus.wb_addr == w_rs) ? bus.wb_data : r_regs[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'd0 :
                      (bus.wb_en && bus.wb_addr == w_rt) ? bus.wb_data : r_regs[w_rt];

    assign w_load_use = r_ex_valid && r_ex_mem_rd && (r_ex_dest != 5'd0) && r_ifid_valid &&
                        ((w_rd_rs && r_ex_dest == w_rs) || (w_rd_rt && r_ex_dest == w_rt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_RUN;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hazard    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_hazard = !bus.flush && w_load_use;
                w_issue  = !bus.flush && !w_load_use && r_ifid_valid;
                if (w_issue && w_op == c_op_halt) w_state_nxt = ST_HALT;
            end
            ST_HALT: begin
                w_hazard = !bus.flush;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ifid_instr <= 32'd0;
            r_ifid_pc4   <= RESET_PC4;
            r_ifid_valid <= 1'b0;
        end else if (bus.flush) begin
            r_ifid_valid <= 1'b0;
        end else if (!w_hazard) begin
            r_ifid_instr <= bus.instruction;
            r_ifid_pc4   <= bus.pc4_dc;
            r_ifid_valid <= bus.if_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= 32'd0;
        end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
            r_regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_op     <= 6'd0;
            r_ex_rs_val <= 32'd0;
            r_ex_rt_val <= 32'd0;
            r_ex_imm    <= 32'd0;
            r_ex_dest   <= 5'd0;
            r_ex_wr_en  <= 1'b0;
            r_ex_mem_rd <= 1'b0;
            r_ex_mem_wr <= 1'b0;
            r_ex_branch <= 1'b0;
            r_ex_pc4    <= RESET_PC4;
        end else begin
            r_ex_valid  <= w_issue;
            r_ex_op     <= w_issue ? w_op : 6'd0;
            r_ex_dest   <= w_issue ? w_dest : 5'd0;
            r_ex_wr_en  <= w_issue && w_wr_en;
            r_ex_mem_rd <= w_issue && w_mem_rd;
            r_ex_mem_wr <= w_issue && w_mem_wr;
            r_ex_branch <= w_issue && w_branch;
            r_ex_rs_val <= w_rs_val;
            r_ex_rt_val <= w_rt_val;
            r_ex_imm    <= {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
            r_ex_pc4    <= r_ifid_pc4;
        end
    end

`ifdef DEC_STATS_EN
    logic [31:0] r_stat_inst, r_stat_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_inst  <= 32'd0;
            r_stat_stall <= 32'd0;
        end else begin
            if (w_issue)                  r_stat_inst  <= r_stat_inst + 32'd1;
            if (w_load_use && !bus.flush) r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign bus.stat_inst  = r_stat_inst;
    assign bus.stat_stall = r_stat_stall;
`endif

    assign bus.hazard    = w_hazard;
    assign bus.halted    = (r_state == ST_HALT);
    assign bus.ex_valid  = r_ex_valid;
    assign bus.ex_op     = r_ex_op;
    assign bus.ex_rs_val = r_ex_rs_val;
    assign bus.ex_rt_val = r_ex_rt_val;
    assign bus.ex_imm    = r_ex_imm;
    assign bus.ex_dest   = r_ex_dest;
    assign bus.ex_wr_en  = r_ex_wr_en;
    assign bus.ex_mem_rd = r_ex_mem_rd;
    assign bus.ex_mem_wr = r_ex_mem_wr;
    assign bus.ex_branch = r_ex_branch;
    assign bus.ex_pc4    = r_ex_pc4;

endmodule

`default_nettype wire

// File: tb/tb_inst_d.sv
// ---------------------------------------------------------------------------
// tb_inst_d : directed self-checking bench for the inst_d decode stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inst_d;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    inst_d_if bus ();

    inst_d #(.NREGS(32), .RESET_PC4(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v);
        bus.instruction = ins;
        bus.pc4_dc      = pc;
        bus.if_valid    = v;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        bus.wb_en   = en;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] add_r8;
    logic [31:0] ldw_r2;

    initial begin
        add_r8 = r_ins(6'h00, 5'd5, 5'd0, 5'd8);
        ldw_r2 = i_ins(6'h0C, 5'd1, 5'd2, 16'h0000);
        rst = 1'b0;
        bus.flush = 1'b0;
        drive(32'd0, 32'd0, 1'b0);
        wb(1'b0, 5'd0, 32'd0);
        tick;
        tick;
        check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_hazard",   {31'd0, bus.hazard},   32'd0);
        check("rst_halted",   {31'd0, bus.halted},   32'd0);
        check("rst_ex_pc4",   bus.ex_pc4,            32'h0);
        rst = 1'b1;

        wb(1'b1, 5'd1, 32'h100); tick;
        wb(1'b1, 5'd7, 32'h77);  tick;
        wb(1'b1, 5'd5, 32'h55);  tick;
        wb(1'b0, 5'd0, 32'd0);

        // ADD R1,R3,R4 with R3 written back while it sits in IF/ID
        drive(r_ins(6'h00, 5'd3, 5'd4, 5'd1), 32'h104, 1'b1); tick;
        drive(32'd0, 32'd0, 1'b0); wb(1'b1, 5'd3, 32'hDEAD_BEEF); tick;
        wb(1'b0, 5'd0, 32'd0);
        check("byp_valid",  {31'd0, bus.ex_valid}, 32'd1);
        check("byp_rs_val", bus.ex_rs_val,         32'hDEAD_BEEF);
        check("byp_dest",   {27'd0, bus.ex_dest},  32'd1);
        check("byp_wr_en",  {31'd0, bus.ex_wr_en}, 32'd1);
        check("byp_pc4",    bus.ex_pc4,            32'h104);

        // ADDI R9,R0,0xFFF0 while R0 is targeted by write-back
        drive(i_ins(6'h01, 5'd0, 5'd9, 16'hFFF0), 32'h108, 1'b1); tick;
        drive(32'd0, 32'd0, 1'b0); wb(1'b1, 5'd0, 32'd5); tick;
        wb(1'b0, 5'd0, 32'd0);
        check("addi_imm",   bus.ex_imm,            32'hFFFF_FFF0);
        check("addi_dest",  {27'd0, bus.ex_dest},  32'd9);
        check("addi_wr_en", {31'd0, bus.ex_wr_en}, 32'd1);
        check("addi_r0",    bus.ex_rs_val,         32'd0);
        check("addi_op",    {26'd0, bus.ex_op},    32'd1);

        // BEQ R1,R7 then an undefined opcode
        drive(i_ins(6'h0F, 5'd1, 5'd7, 16'h0004), 32'h10C, 1'b1); tick;
        drive(i_ins(6'h3F, 5'd1, 5'd7, 16'h0000), 32'h110, 1'b1); tick;
        check("beq_ctrl", {28'd0, bus.ex_wr_en, bus.ex_mem_rd, bus.ex_mem_wr, bus.ex_branch}, 32'h1);
        check("beq_rs",   bus.ex_rs_val, 32'h100);
        check("beq_rt",   bus.ex_rt_val, 32'h77);
        drive(32'd0, 32'd0, 1'b0); tick;
        check("nop_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("nop_ctrl", {28'd0, bus.ex_wr_en, bus.ex_mem_rd, bus.ex_mem_wr, bus.ex_branch}, 32'h0);

        // LDW R2,0(R1) ; SUB R6,R2,R7 -> one stall, one bubble
        drive(ldw_r2, 32'h114, 1'b1); tick;
        drive(r_ins(6'h02, 5'd2, 5'd7, 5'd6), 32'h118, 1'b1); tick;
        check("lu_hazard", {31'd0, bus.hazard},    32'd1);
        check("lu_mem_rd", {31'd0, bus.ex_mem_rd}, 32'd1);
        check("lu_ldw_rs", bus.ex_rs_val,          32'h100);
        drive(32'd0, 32'd0, 1'b0); tick;
        check("lu_bubble", {31'd0, bus.ex_valid},  32'd0);
        check("lu_hz_off", {31'd0, bus.hazard},    32'd0);
        tick;
        check("lu_sub_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("lu_sub_dest",  {27'd0, bus.ex_dest},  32'd6);
        check("lu_sub_rt",    bus.ex_rt_val,         32'h77);

        // LDW R2 ; STW using R2 as Rt, flushed during the stall
        drive(ldw_r2, 32'h11C, 1'b1); tick;
        drive(i_ins(6'h0D, 5'd1, 5'd2, 16'h0008), 32'h120, 1'b1); tick;
        check("fl_pre_hazard", {31'd0, bus.hazard}, 32'd1);
        bus.flush = 1'b1;
        drive(add_r8, 32'h124, 1'b1);
        #1;
        check("fl_hazard", {31'd0, bus.hazard}, 32'd0);
        tick;
        bus.flush = 1'b0;
        drive(32'd0, 32'd0, 1'b0);
        #1;
        check("fl_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("fl_hz_after", {31'd0, bus.hazard},   32'd0);
        tick;
        check("fl_ifid_dead", {31'd0, bus.ex_valid}, 32'd0);

        // asynchronous reset with ADD in both IF/ID and ID/EX
        drive(add_r8, 32'h40, 1'b1); tick;
        drive(add_r8, 32'h44, 1'b1); tick;
        check("pre_rst_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("pre_rst_r5",    bus.ex_rs_val,         32'h55);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid",  {31'd0, bus.ex_valid}, 32'd0);
        check("arst_hazard", {31'd0, bus.hazard},   32'd0);
        check("arst_halted", {31'd0, bus.halted},   32'd0);
        check("arst_pc4",    bus.ex_pc4,            32'h0);
        drive(32'd0, 32'd0, 1'b0);
        tick;
        rst = 1'b1;
        tick;
        check("post_rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        drive(add_r8, 32'h48, 1'b1); tick;
        drive(32'd0, 32'd0, 1'b0); tick;
        check("post_rst_add", {31'd0, bus.ex_valid}, 32'd1);
        check("post_rst_r5",  bus.ex_rs_val,         32'd0);

        // HALT followed by ADD
        drive({6'h11, 26'd0}, 32'h4C, 1'b1); tick;
        drive(add_r8, 32'h50, 1'b1); tick;
        check("halt_halted", {31'd0, bus.halted},   32'd1);
        check("halt_hazard", {31'd0, bus.hazard},   32'd1);
        check("halt_issued", {31'd0, bus.ex_valid}, 32'd1);
        check("halt_op",     {26'd0, bus.ex_op},    32'h11);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("halt_no_issue", {31'd0, bus.ex_valid}, 32'd0);
            check("halt_stuck",    {30'd0, bus.halted, bus.hazard}, 32'd3);
        end
`ifdef DEC_STATS_EN
        check("stat_inst",  bus.stat_inst,  32'd2);
        check("stat_stall", bus.stat_stall, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_d.md
Name: inst_d

Overview:
- Instruction decode stage, directly downstream of instruction fetch.
- Latches the fetched instruction and its PC+4 into an IF/ID register, and decodes the 6-bit opcode.
- Reads a 32x32 register file that has a write-back port.
- Detects load-use hazards, stalls fetch via `hazard`, and presents a registered ID/EX bundle to the execute stage.

Parameters:
- NREGS, 32, number of architectural registers (index width fixed at 5 bits)
- RESET_PC4, 32'h0, value loaded into IF/ID and ID/EX pc4 on reset

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- instruction  in  32  fetched instruction
- pc4_dc  in  32  PC+4 of the fetched instruction
- if_valid  in  1  instruction/pc4_dc are meaningful this cycle
- flush  in  1  taken branch/jump resolved in EX; kill younger instructions
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write-back register index
- wb_data  in  32  write-back data
- hazard  out  1  stall request to fetch (hold PC)
- ex_valid  out  1  ID/EX bundle holds a real instruction
- ex_op  out  6  opcode
- ex_rs_val / ex_rt_val  out  32 each  source operand values
- ex_imm  out  32  sign-extended imm16
- ex_dest  out  5  destination register
- ex_wr_en, ex_mem_rd, ex_mem_wr, ex_branch  out  1 each  control bits
- ex_pc4  out  32  PC+4 carried to EX
- halted  out  1  sticky, HALT has been issued

Behaviour:
- Instruction format: op[31:26], Rs[25:21], Rt[20:16], Rd[15:11], imm[15:0].
- Instruction classes:
  - R-type: even op 000000–001010. Reads Rs and Rt. dest=Rd. wr_en=1.
  - I-type: odd op 000001–001011. Reads Rs. dest=Rt. wr_en=1.
  - LDW 001100: reads Rs. dest=Rt. wr_en=1, mem_rd=1.
  - STW 001101: reads Rs and Rt. mem_wr=1.
  - BZ 001110 and JR 010000: read Rs. branch=1.
  - BEQ 001111: reads Rs and Rt. branch=1.
  - HALT 010001: no reads, no writes.
  - Any other opcode: NOP (valid, all control bits 0).
- Writes to R0 are ignored, and R0 always reads 0.
- Reset (rst=0, asynchronous):
  - All registers clear, including the register file.
  - IF/ID valid=0; ex_valid=0, all ex_* = 0, ex_pc4=RESET_PC4.
  - halted=0, hazard=0.
  - Applies mid-operation with immediate effect.
- Latency:
  - IF/ID captures {instruction, pc4_dc, if_valid} on posedge.
  - Decode and register read are combinational from IF/ID.
  - ID/EX captures on the next posedge, so ex_* appear 2 edges after fetch presents the instruction.
- Register read is write-first: if wb_en and wb_addr==source index (non-zero), the read returns wb_data in that same cycle.
- Load-use hazard (combinational):
  - hazard=1 when ex_valid & ex_mem_rd & ex_dest!=0 & (ex_dest==IF/ID Rs, if Rs is read, or ex_dest==IF/ID Rt, if Rt is read) & IF/ID valid.
  - Stall cycle: IF/ID holds its value, ID/EX loads a bubble (ex_valid=0, control bits 0). Exactly one bubble per load-use.
- Flush has priority over stall:
  - On flush=1, IF/ID valid and ex_valid clear at the next posedge.
  - hazard is forced to 0 while flush=1.
- HALT:
  - When a valid HALT moves into ID/EX (no flush), halted sets and stays set until reset.
  - While halted: hazard=1 constantly, and ID/EX loads only bubbles.
  - The register-file write port stays active while halted.
- A bubble in IF/ID (valid=0) produces ex_valid=0 and never raises hazard.

Optional Feature:
- DEC_STATS_EN defined: adds outputs stat_inst (32) and stat_stall (32).
  - stat_inst increments on every posedge that loads a valid instruction into ID/EX.
  - stat_stall increments on every load-use stall cycle.
  - Both wrap at 2^32 and clear on reset.
- DEC_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with rst=0 mid-stream, while IF/ID holds ADD → ex_valid=0, halted=0, hazard=0 immediately, without waiting for a clock edge; R5 reads 0 afterwards.
- wb_en=1, wb_addr=3, wb_data=32'hDEAD_BEEF in the same cycle ADD R1,R3,R4 sits in IF/ID → next cycle ex_rs_val=32'hDEAD_BEEF (write-first bypass).
- LDW R2,0(R1) followed by SUB R6,R2,R7 → hazard=1 for exactly 1 cycle, one ex_valid=0 bubble, then SUB appears with ex_dest=6.
- LDW R2 then STW using R2 as Rt, with flush=1 during the would-be stall cycle → hazard=0, both IF/ID and ID/EX invalid on the next cycle.
- ADDI R9,R0,imm=16'hFFF0 → ex_imm=32'hFFFF_FFF0, ex_dest=9, ex_wr_en=1. A write to R0 with wb_data=5 leaves R0 reading 0.
- HALT followed by ADD → halted=1 and hazard=1 from the cycle HALT enters ID/EX; ADD never gets ex_valid=1. With DEC_STATS_EN defined, stat_inst equals the count of valid instructions issued.
